// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I single-cycle control unit: opcodes,
// ALU control codes, immediate formats, writeback selects and ALU op classes.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Second-level ALU decode: turns the main decoder's ALU op class plus
// func3/func7[5] into the ALU control code and flags unsupported funct3 values.
module alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       op_code_5,
    output logic [2:0] alu_control,
    output logic       alu_illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        alu_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (func3)
                    // op_code[5] separates R-type from I-ALU, so ADDI never becomes SUB
                    F3_ADD_SUB: alu_control = (op_code_5 && func7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:     alu_control = ALU_SLT;
                    F3_XOR:     alu_control = ALU_XOR;
                    F3_OR:      alu_control = ALU_OR;
                    F3_AND:     alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_ADD;
                        alu_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_control = ALU_ADD;
                alu_illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle RV32I control unit: combinational main decode, branch/jump
// next-PC select, and a run flop that masks architectural writes during reset.
module control_unit
    import rv32_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_source,
    output logic [1:0] result_source,
    output logic [2:0] imm_type,
    output logic [2:0] alu_control,
    output logic       pc_src,
    output logic       illegal_op
);

    logic        run_d;
    logic        run_q;

    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_alu_source;
    result_src_e dec_result_source;
    imm_type_e   dec_imm_type;
    alu_op_e     dec_alu_op;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_illegal;
    logic        alu_illegal;
    logic        func_illegal;

    always_comb begin
        run_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    always_comb begin
        dec_mem_write     = 1'b0;
        dec_reg_write     = 1'b0;
        dec_alu_source    = 1'b0;
        dec_result_source = RES_ALU;
        dec_imm_type      = IMM_I;
        dec_alu_op        = ALUOP_ADD;
        dec_branch        = 1'b0;
        dec_jump          = 1'b0;
        dec_illegal       = 1'b0;
        case (op_code)
            OP_LOAD: begin
                dec_reg_write     = 1'b1;
                dec_alu_source    = 1'b1;
                dec_result_source = RES_MEM;
            end
            OP_STORE: begin
                dec_mem_write  = 1'b1;
                dec_alu_source = 1'b1;
                dec_imm_type   = IMM_S;
            end
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = ALUOP_FUNC;
                dec_illegal   = (func7 != FUNC7_BASE) && (func7 != FUNC7_ALT);
            end
            OP_IALU: begin
                dec_reg_write  = 1'b1;
                dec_alu_source = 1'b1;
                dec_alu_op     = ALUOP_FUNC;
            end
            OP_BRANCH: begin
                dec_imm_type = IMM_B;
                dec_alu_op   = ALUOP_SUB;
                dec_branch   = 1'b1;
                dec_illegal  = (func3 != F3_BEQ);
            end
            OP_JAL: begin
                dec_reg_write     = 1'b1;
                dec_result_source = RES_PC4;
                dec_imm_type      = IMM_J;
                dec_jump          = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (dec_alu_op),
        .func3       (func3),
        .func7_5     (func7[5]),
        .op_code_5   (op_code[5]),
        .alu_control (alu_control),
        .alu_illegal (alu_illegal)
    );

    // Any illegal encoding must never commit a register write or redirect the PC
    always_comb begin
        func_illegal  = dec_illegal | alu_illegal;
        illegal_op    = func_illegal;
        mem_write     = run_q & dec_mem_write;
        reg_write     = run_q & dec_reg_write & ~func_illegal;
        alu_source    = dec_alu_source;
        result_source = dec_result_source;
        imm_type      = dec_imm_type;
        pc_src        = run_q & (((dec_branch & zero) & ~func_illegal) | dec_jump);
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed checks for reset and each instruction class,
// then randomized vectors against a table-driven reference model.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] op_code;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_write;
    logic       reg_write;
    logic       alu_source;
    logic [1:0] result_source;
    logic [2:0] imm_type;
    logic [2:0] alu_control;
    logic       pc_src;
    logic       illegal_op;

    int vectors;
    int miscompares;
    logic run_exp;

    control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_code       (op_code),
        .func3         (func3),
        .func7         (func7),
        .zero          (zero),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_source    (alu_source),
        .result_source (result_source),
        .imm_type      (imm_type),
        .alu_control   (alu_control),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {mw, rw, as, rs[1:0], imm[2:0], alu[2:0], pc_src, illegal}
    function automatic logic [12:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic z, input logic run);
        logic mw, rw, as_, br, jp, ill;
        logic [1:0] rs;
        logic [2:0] imm, alu;
        mw = 0; rw = 0; as_ = 0; br = 0; jp = 0; ill = 0; rs = 0; imm = 0; alu = 0;
        if (op == 7'b0000011) begin
            rw = 1; as_ = 1; rs = 2'b01;
        end else if (op == 7'b0100011) begin
            mw = 1; as_ = 1; imm = 3'b001;
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            rw = 1;
            as_ = (op == 7'b0010011);
            if (f3 == 3'd0)      alu = (op == 7'b0110011 && f7[5]) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) alu = 3'd5;
            else if (f3 == 3'd4) alu = 3'd4;
            else if (f3 == 3'd6) alu = 3'd3;
            else if (f3 == 3'd7) alu = 3'd2;
            else ill = 1;
            if (op == 7'b0110011 && f7 != 7'h00 && f7 != 7'h20) ill = 1;
            if (ill) rw = 0;
        end else if (op == 7'b1100011) begin
            imm = 3'b010; alu = 3'd1; br = 1;
            if (f3 != 3'd0) ill = 1;
        end else if (op == 7'b1101111) begin
            rw = 1; rs = 2'b10; imm = 3'b011; jp = 1;
        end else begin
            ill = 1;
        end
        return {mw & run, rw & run, as_, rs, imm, alu, run & ((br & z & ~ill) | jp), ill};
    endfunction

    function automatic logic [12:0] observed();
        return {mem_write, reg_write, alu_source, result_source, imm_type,
                alu_control, pc_src, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive at negedge, compare combinational outputs 2 time units later,
    // then let the run flop sample rst_n on the following posedge.
    task automatic step(input string tag, input logic rn, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic z);
        @(negedge clk);
        rst_n = rn; op_code = op; func3 = f3; func7 = f7; zero = z;
        #2;
        chk(tag, observed(), model(op, f3, f7, z, run_exp));
        @(posedge clk);
        run_exp = rn;
    endtask

    task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z);
        @(negedge clk);
        op_code = op; func3 = f3; func7 = f7; zero = z;
        #2;
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic rn;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; op_code = 7'b0100011; func3 = 0; func7 = 0; zero = 0;
        run_exp = 1'b0;

        // Reset: two edges with SW presented, then release for one edge
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_mem_write", {12'b0, mem_write}, 13'd0);
        chk("rst_imm_type", {10'b0, imm_type}, 13'd1);
        rst_n = 1'b1;
        @(posedge clk);
        run_exp = 1'b1;
        @(negedge clk);
        #2;
        chk("run_mem_write", {12'b0, mem_write}, 13'd1);

        apply(7'b0000011, 3'd5, 7'h7f, 1'b0);
        chk("lw", observed(), {1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0});
        apply(7'b0100011, 3'd3, 7'h11, 1'b1);
        chk("sw", observed(), {1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0});
        apply(7'b0110011, 3'd0, 7'h00, 1'b0);
        chk("r_add", observed(), {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0});
        apply(7'b0110011, 3'd7, 7'h00, 1'b0);
        chk("r_and", observed(), {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b010, 1'b0, 1'b0});
        apply(7'b0110011, 3'd6, 7'h00, 1'b0);
        chk("r_or", observed(), {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b011, 1'b0, 1'b0});
        apply(7'b0110011, 3'd0, 7'h20, 1'b0);
        chk("r_sub", observed(), {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0});
        apply(7'b0010011, 3'd0, 7'h20, 1'b0);
        chk("addi_no_sub", observed(), {1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0});
        apply(7'b1100011, 3'd0, 7'h00, 1'b0);
        chk("beq_nt", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 3'b001, 1'b0, 1'b0});
        apply(7'b1100011, 3'd0, 7'h00, 1'b1);
        chk("beq_t", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 3'b001, 1'b1, 1'b0});
        apply(7'b1100011, 3'd1, 7'h00, 1'b1);
        chk("bne_illegal", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 3'b001, 1'b0, 1'b1});
        apply(7'b1101111, 3'd2, 7'h33, 1'b0);
        chk("jal_z0", observed(), {1'b0, 1'b1, 1'b0, 2'b10, 3'b011, 3'b000, 1'b1, 1'b0});
        apply(7'b1101111, 3'd2, 7'h33, 1'b1);
        chk("jal_z1", observed(), {1'b0, 1'b1, 1'b0, 2'b10, 3'b011, 3'b000, 1'b1, 1'b0});
        apply(7'b1111111, 3'd0, 7'h00, 1'b1);
        chk("op_illegal", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1});
        apply(7'b0110011, 3'd1, 7'h00, 1'b0);
        chk("sll_illegal", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1});
        apply(7'b0110011, 3'd4, 7'h01, 1'b0);
        chk("r_f7_illegal", observed(), {1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b100, 1'b0, 1'b1});

        // Randomized sweep, including occasional reset pulses to exercise gating
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 7'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h00;
                default: f7 = 7'($urandom);
            endcase
            rn = ($urandom_range(0, 7) != 0);
            step("rand", rn, op, f3, f7, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control unit for the single-cycle RV32I core; sits between instruction fetch/decode and the datapath.
- Decodes op_code/func3/func7 into datapath selects, write enables, ALU operation and immediate format.
- Combines the ALU zero flag into the next-PC select.
- A single run flop gates architectural write enables while the core is held in reset.

Parameters:
- None.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- op_code  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- zero  in  1  ALU result == 0
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- alu_source  out  1  ALU operand B: 0 = rs2, 1 = immediate
- result_source  out  2  writeback select: 00 ALU, 01 memory read data, 10 PC+4, 11 unused
- imm_type  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
- pc_src  out  1  0 = PC+4, 1 = PC+immediate
- illegal_op  out  1  unsupported encoding

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Internal flop run:
  - cleared on any posedge clk with rst_n=0;
  - set to 1 on the first posedge with rst_n=1, then holds 1.
- While run=0: mem_write=0, reg_write=0, pc_src=0. All other outputs still follow the decode.
- With run=1, decode is purely combinational: zero latency, outputs settle in the same cycle as the inputs.
- Main decode by op_code (fields listed as mw, rw, as, rs, imm, aluop, branch, jump):
  - 0000011 LW: mw 0, rw 1, as 1, rs 01, imm 000, aluop ADD, branch 0, jump 0
  - 0100011 SW: mw 1, rw 0, as 1, rs 00, imm 001, aluop ADD
  - 0110011 R-type: mw 0, rw 1, as 0, rs 00, imm 000, aluop FUNC
  - 0010011 I-ALU: mw 0, rw 1, as 1, rs 00, imm 000, aluop FUNC
  - 1100011 BEQ: mw 0, rw 0, as 0, rs 00, imm 010, aluop SUB, branch 1
  - 1101111 JAL: mw 0, rw 1, as 0, rs 10, imm 011, aluop ADD, jump 1
  - any other opcode: all enables 0, as 0, rs 00, imm 000, alu_control 000, illegal_op 1
- FUNC decode (R-type and I-ALU) on func3:
  - 000: SUB (001) iff op_code[5]=1 and func7[5]=1, else ADD (000). I-ALU never yields SUB.
  - 010 → SLT 101; 100 → XOR 100; 110 → OR 011; 111 → AND 010.
  - 001, 011, 101 (shifts/SLTU): alu_control 000, illegal_op 1, reg_write forced 0.
  - R-type with func7 other than 0000000/0100000: illegal_op 1, reg_write 0.
- Branch: func3 must be 000 (BEQ). Any other func3 gives illegal_op 1 and pc_src 0.
- pc_src = run & ((branch & zero) | jump). JAL sets pc_src=1 regardless of zero.
- func3/func7 are ignored for LW, SW and JAL; they never raise illegal_op there.
- No X on any output for any input combination; every case arm fully assigns all outputs.

Decomposition:
- Shared package (rv32_ctrl_pkg) holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL);
  - enum alu_ctrl_e, enum imm_type_e, enum result_src_e, enum alu_op_e (ADD, SUB, FUNC).
- One sub-module, alu_decoder: takes alu_op, func3, func7[5] and op_code[5]; produces alu_control and its illegal flag.
- Main decoder, pc_src logic and the run flop stay in control_unit.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with op_code=0100011 → mem_write=0, imm_type=001. Release for 1 edge → mem_write=1.
- LW 0000011 → imm_type 000, mem_write 0, reg_write 1, alu_source 1, result_source 01, alu_control 000. SW 0100011 → imm_type 001, mem_write 1, reg_write 0, alu_source 1, alu_control 000.
- R-type 0110011 with func7=0:
  - func3=000 → alu_control 000; func3=111 → 010; func3=110 → 011.
  - All three: reg_write 1, alu_source 0, result_source 00.
  - func7=0100000, func3=000 → alu_control 001.
- BEQ 1100011, zero=0 → imm_type 010, alu_control 001, mem_write 0, reg_write 0, alu_source 0, pc_src 0. Then zero=1 → pc_src 1.
- JAL 1101111 → imm_type 011, reg_write 1, result_source 10, pc_src 1 for zero=0 and for zero=1.
- Illegal: op_code=1111111 → all enables 0, illegal_op 1. R-type func3=001 → illegal_op 1, reg_write 0.
